// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: control requests, PC redirect, instruction memory port and decoded fields.
// master = control/memory side, slave = the fetch unit.
interface instr_fetch_unit_if;
    logic        fetch_start;
    logic        pc_load;
    logic [31:0] pc_next;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        illegal;

    modport master (
        output fetch_start, pc_load, pc_next, mem_rdata,
        input  mem_addr, mem_rd, busy, instr_valid, pc, instr,
               opcode, rd, funct3, rs1, rs2, funct7, imm, illegal
    );

    modport slave (
        input  fetch_start, pc_load, pc_next, mem_rdata,
        output mem_addr, mem_rd, busy, instr_valid, pc, instr,
               opcode, rd, funct3, rs1, rs2, funct7, imm, illegal
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns PC and IR, reads one word per fetch_start after a fixed memory latency,
// then presents decoded fields and the sign-extended immediate.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_LATENCY = 2
) (
    input logic               clk,
    input logic               rst,
    instr_fetch_unit_if.slave bus
);
    localparam int            CW       = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] LAT_INIT = CW'(MEM_LATENCY - 1);
    localparam logic [CW-1:0] LAT_ONE  = CW'(1);
    localparam logic [31:0]   NOP      = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, READ, WAIT, DONE} fetchState_t;

    fetchState_t   state;
    logic [31:0]   pcReg;
    logic [31:0]   irReg;
    logic [CW-1:0] latCount;
    logic          memRd;
    logic          instrValid;
    logic          busyReg;
    logic [31:0]   immVal;
    logic          illegalOp;

    // Counter is loaded in READ and the word is captured in the WAIT cycle where it reaches
    // zero, so the capture lands exactly MEM_LATENCY cycles after the mem_rd cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            pcReg      <= RESET_PC;
            irReg      <= NOP;
            latCount   <= '0;
            memRd      <= 1'b0;
            instrValid <= 1'b0;
            busyReg    <= 1'b0;
        end else begin
            memRd      <= 1'b0;
            instrValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.pc_load) begin
                        pcReg <= {bus.pc_next[31:2], 2'b00};
                    end
                    if (bus.fetch_start) begin
                        state   <= READ;
                        memRd   <= 1'b1;
                        busyReg <= 1'b1;
                    end
                end
                READ: begin
                    latCount <= LAT_INIT;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (latCount == '0) begin
                        irReg      <= bus.mem_rdata;
                        pcReg      <= pcReg + 32'd4;
                        instrValid <= 1'b1;
                        state      <= DONE;
                    end else begin
                        latCount <= latCount - LAT_ONE;
                    end
                end
                DONE: begin
                    busyReg <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    busyReg <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        immVal    = '0;
        illegalOp = 1'b0;
        case (irReg[6:0])
            7'b0010011, 7'b0000011, 7'b1100111:
                immVal = {{20{irReg[31]}}, irReg[31:20]};
            7'b0100011:
                immVal = {{20{irReg[31]}}, irReg[31:25], irReg[11:7]};
            7'b1100011:
                immVal = {{19{irReg[31]}}, irReg[31], irReg[7], irReg[30:25], irReg[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                immVal = {irReg[31:12], 12'b0};
            7'b1101111:
                immVal = {{11{irReg[31]}}, irReg[31], irReg[19:12], irReg[20], irReg[30:21], 1'b0};
            7'b0110011:
                immVal = '0;
            default:
                illegalOp = 1'b1;
        endcase
    end

    assign bus.mem_addr    = pcReg;
    assign bus.mem_rd      = memRd;
    assign bus.busy        = busyReg;
    assign bus.instr_valid = instrValid;
    assign bus.pc          = pcReg;
    assign bus.instr       = irReg;
    assign bus.opcode      = irReg[6:0];
    assign bus.rd          = irReg[11:7];
    assign bus.funct3      = irReg[14:12];
    assign bus.rs1         = irReg[19:15];
    assign bus.rs2         = irReg[24:20];
    assign bus.funct7      = irReg[31:25];
    assign bus.imm         = immVal;
    assign bus.illegal     = illegalOp;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a two-cycle-latency memory that only drives
// valid data in the exact cycle the read result is due.
module tb_instr_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_unit_if bus();

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .MEM_LATENCY(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int checkCount = 0;
    int passCount  = 0;
    int validCount = 0;

    logic [1:0]  rdPipe    = 2'b00;
    logic [31:0] addrPipe0 = '0;
    logic [31:0] addrPipe1 = '0;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0073_0293;
            32'h0000_0004: return 32'hFE52_AE23;
            32'h0000_0100: return 32'hFE00_0CE3;
            32'h0000_0104: return 32'h00C0_006F;
            32'h0000_0108: return 32'h00A0_0513;
            32'h0000_0200: return 32'h1234_5537;
            32'hFFFF_FFFC: return 32'hFFFF_FFFF;
            default:       return 32'h0000_0013;
        endcase
    endfunction

    // Read data is only meaningful two cycles after the strobe; otherwise the bus carries junk.
    always @(posedge clk) begin
        rdPipe    <= {rdPipe[0], bus.mem_rd};
        addrPipe0 <= bus.mem_addr;
        addrPipe1 <= addrPipe0;
    end
    assign bus.mem_rdata = rdPipe[1] ? memWord(addrPipe1) : 32'hDEAD_BEEF;

    always @(negedge clk) begin
        if (bus.instr_valid === 1'b1) validCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    endtask

    task automatic applyStimulus(input logic fs, input logic load, input logic [31:0] next);
        bus.fetch_start = fs;
        bus.pc_load     = load;
        bus.pc_next     = next;
    endtask

    // Called at a negedge; pokeCycle>0 pulses fetch_start+pc_load in that cycle of the fetch.
    task automatic doFetch(input logic load, input logic [31:0] next, input int pokeCycle,
                           output int lat, output int rdCycle, output logic [31:0] rdAddr);
        lat     = 99;
        rdCycle = 99;
        rdAddr  = '1;
        applyStimulus(1'b1, load, next);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == pokeCycle) applyStimulus(1'b1, 1'b1, 32'h0000_2000);
            else                applyStimulus(1'b0, 1'b0, 32'h0);
            if (bus.mem_rd === 1'b1 && rdCycle == 99) begin
                rdCycle = c;
                rdAddr  = bus.mem_addr;
            end
            if (bus.instr_valid === 1'b1) begin
                lat = c;
                break;
            end
        end
        applyStimulus(1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        int          lat;
        int          rdCycle;
        logic [31:0] rdAddr;
        int          v0;

        applyStimulus(1'b0, 1'b0, 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rstBusy", 32'(bus.busy), 32'd0);
        checkOutput("rstMemRd", 32'(bus.mem_rd), 32'd0);
        checkOutput("rstValid", 32'(bus.instr_valid), 32'd0);
        checkOutput("rstPc", bus.pc, 32'h0);
        checkOutput("rstInstr", bus.instr, 32'h0000_0013);
        rst = 1'b1;
        @(negedge clk);

        // addi x5,x6,7 at address 0
        doFetch(1'b0, 32'h0, 0, lat, rdCycle, rdAddr);
        checkOutput("t1RdCycle", 32'(rdCycle), 32'd1);
        checkOutput("t1RdAddr", rdAddr, 32'h0);
        checkOutput("t1Latency", 32'(lat), 32'd4);
        checkOutput("t1Busy", 32'(bus.busy), 32'd1);
        checkOutput("t1Opcode", 32'(bus.opcode), 32'h13);
        checkOutput("t1Rd", 32'(bus.rd), 32'd5);
        checkOutput("t1Rs1", 32'(bus.rs1), 32'd6);
        checkOutput("t1Funct3", 32'(bus.funct3), 32'd0);
        checkOutput("t1Imm", bus.imm, 32'd7);
        checkOutput("t1Pc", bus.pc, 32'h4);
        @(negedge clk);
        checkOutput("t1ValidDrop", 32'(bus.instr_valid), 32'd0);
        checkOutput("t1BusyDrop", 32'(bus.busy), 32'd0);

        // sw x5,-4(x5)
        doFetch(1'b0, 32'h0, 0, lat, rdCycle, rdAddr);
        checkOutput("t2Opcode", 32'(bus.opcode), 32'h23);
        checkOutput("t2Imm", bus.imm, 32'hFFFF_FFFC);
        checkOutput("t2Rs2", 32'(bus.rs2), 32'd5);
        checkOutput("t2Illegal", 32'(bus.illegal), 32'd0);
        checkOutput("t2Pc", bus.pc, 32'h8);
        @(negedge clk);

        // Redirect and fetch in the same cycle; low PC bits are dropped
        doFetch(1'b1, 32'h0000_0103, 0, lat, rdCycle, rdAddr);
        checkOutput("t3RdAddr", rdAddr, 32'h100);
        checkOutput("t3Pc", bus.pc, 32'h104);
        checkOutput("t3Opcode", 32'(bus.opcode), 32'h63);
        checkOutput("t3Imm", bus.imm, 32'hFFFF_FFF8);
        @(negedge clk);

        // Requests during WAIT are ignored
        v0 = validCount;
        doFetch(1'b0, 32'h0, 2, lat, rdCycle, rdAddr);
        checkOutput("t4Latency", 32'(lat), 32'd4);
        checkOutput("t4Pc", bus.pc, 32'h108);
        checkOutput("t4Opcode", 32'(bus.opcode), 32'h6F);
        checkOutput("t4Imm", bus.imm, 32'd12);
        repeat (4) @(negedge clk);
        checkOutput("t4ValidCount", 32'(validCount - v0), 32'd1);
        checkOutput("t4Busy", 32'(bus.busy), 32'd0);
        checkOutput("t4PcHold", bus.pc, 32'h108);

        // Reset while waiting on memory aborts the fetch
        v0 = validCount;
        applyStimulus(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t5Busy", 32'(bus.busy), 32'd0);
        checkOutput("t5Pc", bus.pc, 32'h0);
        checkOutput("t5Instr", bus.instr, 32'h0000_0013);
        checkOutput("t5MemRd", 32'(bus.mem_rd), 32'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("t5NoValid", 32'(validCount - v0), 32'd0);
        checkOutput("t5InstrHold", bus.instr, 32'h0000_0013);

        // PC wrap and an unsupported opcode
        doFetch(1'b1, 32'hFFFF_FFFC, 0, lat, rdCycle, rdAddr);
        checkOutput("t6RdAddr", rdAddr, 32'hFFFF_FFFC);
        checkOutput("t6PcWrap", bus.pc, 32'h0);
        checkOutput("t6Instr", bus.instr, 32'hFFFF_FFFF);
        checkOutput("t6Illegal", 32'(bus.illegal), 32'd1);
        checkOutput("t6Imm", bus.imm, 32'h0);
        @(negedge clk);

        // lui x10,0x12345
        doFetch(1'b1, 32'h0000_0200, 0, lat, rdCycle, rdAddr);
        checkOutput("t7Opcode", 32'(bus.opcode), 32'h37);
        checkOutput("t7Rd", 32'(bus.rd), 32'd10);
        checkOutput("t7Imm", bus.imm, 32'h1234_5000);
        checkOutput("t7Illegal", 32'(bus.illegal), 32'd0);
        checkOutput("t7Pc", bus.pc, 32'h204);
        @(negedge clk);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
